usrt_tx_sched: RTL and testbench



---
 rtl/usrt_pkg.sv | 15 +
 rtl/usrt_tx_sched_if.sv | 42 ++++
 rtl/usrt_rr_arb2.sv | 29 ++
 rtl/usrt_tx_sched.sv | 158 +++++++++++++++
 tb/tb_usrt_tx_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: scheduler state encoding and default frame/baud
// constants, common to the transmit scheduler and the shift-register benches.
package usrt_pkg;

    localparam int DATA_W   = 8;   // frame payload width
    localparam int BAUD_W   = 14;  // baud divisor width
    localparam int BAUD_RST = 87;  // divisor out of reset

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } usrt_state_e;

endpackage

// File: rtl/usrt_tx_sched_if.sv
// Host/requester/txshift-facing bundle of the transmit scheduler.
// slave  : scheduler view (requests, baud config and Pready in; Ready, Tx_*, status out)
// master : host/bench view (the mirror image)
interface usrt_tx_sched_if #(
    parameter int DATA_W = usrt_pkg::DATA_W,
    parameter int BAUD_W = usrt_pkg::BAUD_W
);
    logic [BAUD_W-1:0] i_Baud_Cfg;
    logic              i_Baud_Load;
    logic              i_Req0_Valid;
    logic              i_Req1_Valid;
    logic [DATA_W-1:0] i_Req0_Data;
    logic [DATA_W-1:0] i_Req1_Data;
    logic              o_Req0_Ready;
    logic              o_Req1_Ready;
    logic              o_Tx_Enable;
    logic [DATA_W-1:0] o_Tx_Data;
    logic [BAUD_W-1:0] o_Tx_Baud;
    logic              i_Tx_Pready;
    logic              o_Busy;
    logic [1:0]        o_Grant;
    logic              o_Timeout;
    logic [15:0]       o_Frame_Count;

    modport slave (
        input  i_Baud_Cfg, i_Baud_Load,
        input  i_Req0_Valid, i_Req1_Valid, i_Req0_Data, i_Req1_Data,
        input  i_Tx_Pready,
        output o_Req0_Ready, o_Req1_Ready,
        output o_Tx_Enable, o_Tx_Data, o_Tx_Baud,
        output o_Busy, o_Grant, o_Timeout, o_Frame_Count
    );

    modport master (
        output i_Baud_Cfg, i_Baud_Load,
        output i_Req0_Valid, i_Req1_Valid, i_Req0_Data, i_Req1_Data,
        output i_Tx_Pready,
        input  o_Req0_Ready, o_Req1_Ready,
        input  o_Tx_Enable, o_Tx_Data, o_Tx_Baud,
        input  o_Busy, o_Grant, o_Timeout, o_Frame_Count
    );
endinterface

// File: rtl/usrt_rr_arb2.sv
// Two-way round-robin arbiter.
// i_Valid   : request vector {req1, req0}
// i_Advance : a grant was consumed this cycle; remember the winner
// o_Grant   : one-hot pick (combinational), 0 when nobody requests
module usrt_rr_arb2 (
    input  logic       i_Pclk,
    input  logic       i_Presetn,
    input  logic [1:0] i_Valid,
    input  logic       i_Advance,
    output logic [1:0] o_Grant
);
    // Index of the last winner; starts at 1 so req0 takes the first tie.
    logic last_q;

    always_comb begin
        o_Grant = i_Valid;
        if (i_Valid == 2'b11) begin
            o_Grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            last_q <= 1'b1;
        end else if (i_Advance) begin
            last_q <= o_Grant[1];
        end
    end
endmodule

// File: rtl/usrt_tx_sched.sv
// USRT transmit scheduler: shares one txshift between two byte requesters,
// drives the Enable/Data/Pready handshake, owns the baud divisor register.
// Ports:
//   i_Pclk, i_Presetn : clock, async active-low reset
//   bus (slave)       : requester handshakes, baud config, txshift control,
//                       status (Busy, Grant, Timeout pulse, Frame_Count)
module usrt_tx_sched
    import usrt_pkg::*;
#(
    parameter int DATA_W     = usrt_pkg::DATA_W,
    parameter int BAUD_W     = usrt_pkg::BAUD_W,
    parameter int BAUD_RST   = usrt_pkg::BAUD_RST,
    parameter int TIMEOUT    = 2048,
    parameter int GAP_CYCLES = 1
) (
    input  logic           i_Pclk,
    input  logic           i_Presetn,
    usrt_tx_sched_if.slave bus
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    usrt_state_e       state_q;
    logic [1:0]        pick;
    logic              accept;
    logic              prev_q;
    logic              rise_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              en_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        grant_q;
    logic              tmo_q;
    logic [15:0]       frame_cnt_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_pend_q;
    logic              baud_pend_vld_q;
    logic              gap_done;

    usrt_rr_arb2 u_arb (
        .i_Pclk    (i_Pclk),
        .i_Presetn (i_Presetn),
        .i_Valid   ({bus.i_Req1_Valid, bus.i_Req0_Valid}),
        .i_Advance (accept),
        .o_Grant   (pick)
    );

    assign accept   = (state_q == ST_IDLE) && (pick != 2'b00);
    assign gap_done = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);

    assign bus.o_Req0_Ready  = (state_q == ST_IDLE) & pick[0];
    assign bus.o_Req1_Ready  = (state_q == ST_IDLE) & pick[1];
    assign bus.o_Tx_Enable   = en_q;
    assign bus.o_Tx_Data     = data_q;
    assign bus.o_Tx_Baud     = baud_q;
    assign bus.o_Busy        = (state_q != ST_IDLE);
    assign bus.o_Grant       = grant_q;
    assign bus.o_Timeout     = tmo_q;
    assign bus.o_Frame_Count = frame_cnt_q;

    // Registered Pready edge detect. Masked outside SEND so a level that is
    // already high when the frame starts can never count as completion.
    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= bus.i_Tx_Pready;
            rise_q <= bus.i_Tx_Pready & ~prev_q & (state_q == ST_SEND);
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            data_q      <= '0;
            grant_q     <= 2'b00;
            tmo_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_SEND;
                        en_q      <= 1'b1;
                        data_q    <= pick[1] ? bus.i_Req1_Data : bus.i_Req0_Data;
                        grant_q   <= pick;
                        tmo_cnt_q <= '0;
                    end
                end
                ST_SEND: begin
                    if (rise_q || (tmo_cnt_q == TMO_LAST)) begin
                        state_q   <= ST_GAP;
                        en_q      <= 1'b0;
                        data_q    <= '0;
                        grant_q   <= 2'b00;
                        gap_cnt_q <= '0;
                        // Completion wins over an expiry in the same cycle.
                        if (rise_q) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            tmo_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // Baud register: loads in IDLE apply immediately; loads during a frame
    // are parked (latest wins) and applied on the edge that re-enters IDLE,
    // so txshift never sees the divisor change mid-frame.
    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            baud_q          <= BAUD_W'(BAUD_RST);
            baud_pend_q     <= '0;
            baud_pend_vld_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (bus.i_Baud_Load) begin
                baud_q <= bus.i_Baud_Cfg;
            end
        end else begin
            if (bus.i_Baud_Load) begin
                baud_pend_q     <= bus.i_Baud_Cfg;
                baud_pend_vld_q <= 1'b1;
            end
            if (gap_done) begin
                if (bus.i_Baud_Load) begin
                    baud_q <= bus.i_Baud_Cfg;
                end else if (baud_pend_vld_q) begin
                    baud_q <= baud_pend_q;
                end
                baud_pend_vld_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usrt_tx_sched.sv
// Self-checking bench for usrt_tx_sched with a stubbed txshift Pready.
module tb_usrt_tx_sched;
    import usrt_pkg::*;

    localparam int TB_TIMEOUT = 32;
    localparam int TB_GAP     = 2;
    localparam int LAT        = 5;
    localparam int M_AUTO = 0, M_ST0 = 1, M_ST1 = 2, M_MAN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usrt_tx_sched_if #(.DATA_W(8), .BAUD_W(14)) bus ();

    usrt_tx_sched #(
        .DATA_W(8), .BAUD_W(14), .BAUD_RST(87),
        .TIMEOUT(TB_TIMEOUT), .GAP_CYCLES(TB_GAP)
    ) dut (
        .i_Pclk    (clk),
        .i_Presetn (rst_n),
        .bus       (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   mode   = M_MAN;
    logic man_p  = 1'b0;
    logic auto_q = 1'b0;
    int   acnt   = 0;
    bit   tb_last = 1'b1;
    logic [9:0] sbq [$];   // expected {grant, data} per accepted frame

    assign bus.i_Tx_Pready = (mode == M_AUTO) ? auto_q :
                             (mode == M_ST1)  ? 1'b1   :
                             (mode == M_MAN)  ? man_p  : 1'b0;

    // txshift stand-in: Pready rises LAT cycles into a frame, drops with Enable.
    always @(negedge clk) begin
        if (!bus.o_Tx_Enable) begin
            acnt   = 0;
            auto_q = 1'b0;
        end else if (acnt == LAT) begin
            auto_q = 1'b1;
        end else begin
            acnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Round-robin expectation: on a tie the requester that did not win last goes.
    task automatic push_exp(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        bit win;
        win = (v == 2'b11) ? ~tb_last : v[1];
        tb_last = win;
        sbq.push_back(win ? {2'b10, d1} : {2'b01, d0});
    endtask

    task automatic wait_en(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_Tx_Enable === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_Baud_Cfg = '0; bus.i_Baud_Load = 1'b0;
        bus.i_Req0_Valid = 1'b0; bus.i_Req1_Valid = 1'b0;
        bus.i_Req0_Data = '0; bus.i_Req1_Data = '0;
        man_p = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tb_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] v;
        rst_n = 1'b0;
        bus.i_Baud_Cfg = '0; bus.i_Baud_Load = 1'b0;
        bus.i_Req0_Valid = 1'b0; bus.i_Req1_Valid = 1'b0;
        bus.i_Req0_Data = '0; bus.i_Req1_Data = '0;
        repeat (2) @(negedge clk);
        v = {bus.o_Tx_Enable, bus.o_Busy, bus.o_Timeout, bus.o_Req0_Ready,
             bus.o_Req1_Ready, 1'b0, bus.o_Grant, 2'b00};
        checks++;
        if (v !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0", v);
        end
        checks++;
        if (bus.o_Tx_Data !== 8'h00 || bus.o_Frame_Count !== 16'd0) begin
            errors++; $display("FAIL reset_data: got data=%h cnt=%h want 0/0", bus.o_Tx_Data, bus.o_Frame_Count);
        end
        checks++;
        if (bus.o_Tx_Baud !== 14'd87) begin
            errors++; $display("FAIL reset_baud: got %0d want 87", bus.o_Tx_Baud);
        end
        rst_n = 1'b1;
        tb_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [9:0] e;
        mode = M_MAN; man_p = 1'b0;
        bus.i_Req0_Data = 8'h53; bus.i_Req0_Valid = 1'b1;
        push_exp(2'b01, 8'h53, 8'h00);
        #1;
        checks++;
        if (bus.o_Req0_Ready !== 1'b1 || bus.o_Req1_Ready !== 1'b0) begin
            errors++; $display("FAIL single_ready: got r0=%b r1=%b want 1/0", bus.o_Req0_Ready, bus.o_Req1_Ready);
        end
        @(negedge clk);
        bus.i_Req0_Valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (bus.o_Tx_Enable !== 1'b1 || bus.o_Busy !== 1'b1 || bus.o_Req0_Ready !== 1'b0) begin
            errors++; $display("FAIL single_start: got en=%b busy=%b rdy=%b want 1/1/0", bus.o_Tx_Enable, bus.o_Busy, bus.o_Req0_Ready);
        end
        checks++;
        if ({bus.o_Grant, bus.o_Tx_Data} !== e) begin
            errors++; $display("FAIL single_data: got %h want %h", {bus.o_Grant, bus.o_Tx_Data}, e);
        end
        repeat (3) @(negedge clk);
        man_p = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_Tx_Enable !== 1'b1 || bus.o_Tx_Data !== 8'h53) begin
            errors++; $display("FAIL single_latency: got en=%b data=%h want 1/53", bus.o_Tx_Enable, bus.o_Tx_Data);
        end
        @(negedge clk);
        man_p = 1'b0;
        checks++;
        if (bus.o_Tx_Enable !== 1'b0 || bus.o_Frame_Count !== 16'd1 || bus.o_Grant !== 2'b00 ||
            bus.o_Tx_Data !== 8'h00 || bus.o_Busy !== 1'b1) begin
            errors++; $display("FAIL single_done: got en=%b cnt=%0d g=%b d=%h busy=%b want 0/1/00/00/1",
                bus.o_Tx_Enable, bus.o_Frame_Count, bus.o_Grant, bus.o_Tx_Data, bus.o_Busy);
        end
        repeat (TB_GAP - 1) @(negedge clk);
        checks++;
        if (bus.o_Busy !== 1'b1) begin
            errors++; $display("FAIL single_gap_len: got busy=%b want 1", bus.o_Busy);
        end
        @(negedge clk);
        checks++;
        if (bus.o_Busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got busy=%b want 0", bus.o_Busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        logic en, prev_en;
        int nf, low;
        bit ok;
        do_reset();
        mode = M_AUTO;
        bus.i_Req0_Data = 8'hA5; bus.i_Req1_Data = 8'h3C;
        bus.i_Req0_Valid = 1'b1; bus.i_Req1_Valid = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(2'b11, 8'hA5, 8'h3C);
        nf = 0; low = 0; prev_en = 1'b0;
        for (int i = 0; i < 400 && nf < 4; i++) begin
            @(negedge clk);
            en = bus.o_Tx_Enable;
            if (en && !prev_en) begin
                e = sbq.pop_front();
                checks++;
                if ({bus.o_Grant, bus.o_Tx_Data} !== e) begin
                    errors++; $display("FAIL b2b_frame%0d: got %h want %h", nf, {bus.o_Grant, bus.o_Tx_Data}, e);
                end
                if (nf > 0) begin
                    checks++;
                    if (low !== TB_GAP + 1) begin
                        errors++; $display("FAIL b2b_gap%0d: got %0d want %0d", nf, low, TB_GAP + 1);
                    end
                end
                nf++;
                low = 0;
                if (nf == 4) begin
                    bus.i_Req0_Valid = 1'b0; bus.i_Req1_Valid = 1'b0;
                end
            end
            if (!en) low++;
            prev_en = en;
        end
        checks++;
        if (nf !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d frames want 4", nf);
            bus.i_Req0_Valid = 1'b0; bus.i_Req1_Valid = 1'b0;
        end
        wait_idle(ok);
        checks++;
        if (!ok || bus.o_Frame_Count !== 16'd4) begin
            errors++; $display("FAIL b2b_fcnt: got %0d idle=%b want 4/1", bus.o_Frame_Count, ok);
        end
    endtask

    task automatic test_baud();
        logic [9:0] e;
        logic [13:0] bad;
        bit ok, seen_bad;
        mode = M_AUTO;
        bus.i_Req0_Data = 8'h11; bus.i_Req0_Valid = 1'b1;
        push_exp(2'b01, 8'h11, 8'h00);
        @(negedge clk);
        bus.i_Req0_Valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (bus.o_Tx_Enable !== 1'b1 || {bus.o_Grant, bus.o_Tx_Data} !== e) begin
            errors++; $display("FAIL baud_frame: got en=%b %h want 1 %h", bus.o_Tx_Enable, {bus.o_Grant, bus.o_Tx_Data}, e);
        end
        bus.i_Baud_Cfg = 14'd50; bus.i_Baud_Load = 1'b1;
        @(negedge clk);
        bus.i_Baud_Cfg = 14'd43;
        seen_bad = 1'b0; bad = '0;
        @(negedge clk);
        bus.i_Baud_Load = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.o_Busy !== 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.o_Tx_Baud !== 14'd87 && !seen_bad) begin
                seen_bad = 1'b1; bad = bus.o_Tx_Baud;
            end
            @(negedge clk);
        end
        checks++;
        if (seen_bad) begin
            errors++; $display("FAIL baud_hold: got %0d during frame want 87", bad);
        end
        checks++;
        if (!ok || bus.o_Tx_Baud !== 14'd43) begin
            errors++; $display("FAIL baud_apply: got %0d idle=%b want 43/1", bus.o_Tx_Baud, ok);
        end
        bus.i_Baud_Cfg = 14'd60; bus.i_Baud_Load = 1'b1;
        @(negedge clk);
        bus.i_Baud_Load = 1'b0;
        checks++;
        if (bus.o_Tx_Baud !== 14'd60) begin
            errors++; $display("FAIL baud_idle_load: got %0d want 60", bus.o_Tx_Baud);
        end
    endtask

    // Runs one frame with the current Pready stub mode and expects expiry.
    task automatic run_timeout(input string nm, input logic [1:0] v, input logic [7:0] d);
        logic [9:0] e;
        logic [15:0] fc;
        int hi;
        fc = bus.o_Frame_Count;
        if (v[1]) begin bus.i_Req1_Data = d; bus.i_Req1_Valid = 1'b1; end
        else      begin bus.i_Req0_Data = d; bus.i_Req0_Valid = 1'b1; end
        push_exp(v, d, d);
        @(negedge clk);
        bus.i_Req0_Valid = 1'b0; bus.i_Req1_Valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if ({bus.o_Grant, bus.o_Tx_Data} !== e) begin
            errors++; $display("FAIL %s_frame: got %h want %h", nm, {bus.o_Grant, bus.o_Tx_Data}, e);
        end
        hi = 0;
        for (int i = 0; i < 4 * TB_TIMEOUT; i++) begin
            if (bus.o_Tx_Enable !== 1'b1) break;
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== TB_TIMEOUT || bus.o_Timeout !== 1'b1) begin
            errors++; $display("FAIL %s_expiry: got cycles=%0d pulse=%b want %0d/1", nm, hi, bus.o_Timeout, TB_TIMEOUT);
        end
        checks++;
        if (bus.o_Frame_Count !== fc) begin
            errors++; $display("FAIL %s_fcnt: got %0d want %0d", nm, bus.o_Frame_Count, fc);
        end
        @(negedge clk);
        checks++;
        if (bus.o_Timeout !== 1'b0) begin
            errors++; $display("FAIL %s_pulse_width: got %b want 0", nm, bus.o_Timeout);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        logic [15:0] fc;
        bit ok;
        mode = M_ST0;
        run_timeout("tmo", 2'b10, 8'h77);
        fc = bus.o_Frame_Count;
        mode = M_AUTO;
        bus.i_Req0_Data = 8'h21; bus.i_Req0_Valid = 1'b1;
        push_exp(2'b01, 8'h21, 8'h00);
        wait_en(1'b1, ok);
        bus.i_Req0_Valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (!ok || {bus.o_Grant, bus.o_Tx_Data} !== e) begin
            errors++; $display("FAIL tmo_next: got %h started=%b want %h", {bus.o_Grant, bus.o_Tx_Data}, ok, e);
        end
        wait_idle(ok);
        checks++;
        if (!ok || bus.o_Frame_Count !== fc + 16'd1) begin
            errors++; $display("FAIL tmo_next_fcnt: got %0d want %0d", bus.o_Frame_Count, fc + 16'd1);
        end
    endtask

    task automatic test_stuck_high();
        bit ok;
        mode = M_ST1;
        repeat (3) @(negedge clk);
        run_timeout("stuck1", 2'b01, 8'h5A);
        mode = M_MAN;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        mode = M_ST0;
        bus.i_Req1_Data = 8'h99; bus.i_Req1_Valid = 1'b1;
        push_exp(2'b10, 8'h00, 8'h99);
        @(negedge clk);
        bus.i_Req1_Valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (bus.o_Tx_Enable !== 1'b1 || {bus.o_Grant, bus.o_Tx_Data} !== e) begin
            errors++; $display("FAIL rstmid_frame: got en=%b %h want 1 %h", bus.o_Tx_Enable, {bus.o_Grant, bus.o_Tx_Data}, e);
        end
        bus.i_Baud_Cfg = 14'd99; bus.i_Baud_Load = 1'b1;
        @(negedge clk);
        bus.i_Baud_Load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_Tx_Enable !== 1'b0 || bus.o_Busy !== 1'b0 || bus.o_Grant !== 2'b00 ||
            bus.o_Tx_Data !== 8'h00 || bus.o_Frame_Count !== 16'd0 || bus.o_Tx_Baud !== 14'd87) begin
            errors++; $display("FAIL rstmid_async: got en=%b busy=%b g=%b d=%h cnt=%0d baud=%0d want 0/0/00/00/0/87",
                bus.o_Tx_Enable, bus.o_Busy, bus.o_Grant, bus.o_Tx_Data, bus.o_Frame_Count, bus.o_Tx_Baud);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tb_last = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.o_Tx_Baud !== 14'd87 || bus.o_Busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_pending: got baud=%0d busy=%b want 87/0", bus.o_Tx_Baud, bus.o_Busy);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] e;
        bit ok;
        mode = M_AUTO;
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        @(negedge clk);
        checks++;
        if (bus.o_Frame_Count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preset: got %h want ffff", bus.o_Frame_Count);
        end
        bus.i_Req0_Data = 8'h0F; bus.i_Req0_Valid = 1'b1;
        push_exp(2'b01, 8'h0F, 8'h00);
        wait_en(1'b1, ok);
        bus.i_Req0_Valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (!ok || {bus.o_Grant, bus.o_Tx_Data} !== e) begin
            errors++; $display("FAIL wrap_frame: got %h started=%b want %h", {bus.o_Grant, bus.o_Tx_Data}, ok, e);
        end
        wait_idle(ok);
        checks++;
        if (!ok || bus.o_Frame_Count !== 16'h0000) begin
            errors++; $display("FAIL wrap_count: got %h want 0000", bus.o_Frame_Count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_baud();
        test_timeout();
        test_stuck_high();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
